// File: rtl/max_pq_pkg.sv
// Shared types for the max-heap priority queue: op codes, sift FSM states and
// the child-select encoding returned by the three-way comparator.
package max_pq_pkg;

  typedef enum logic [1:0] {
    PQ_NOP  = 2'b00,
    PQ_PUSH = 2'b01,
    PQ_POP  = 2'b10,
    PQ_TOP  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_SIFT_UP   = 2'b01,
    S_SIFT_DOWN = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SEL_PARENT = 2'b00,
    SEL_LEFT   = 2'b01,
    SEL_RIGHT  = 2'b10
  } sel_t;

endpackage

// File: rtl/max_pq_sel3.sv
// Largest-of parent/left/right for one sift-down step; combinational, no backpressure.
// Strict compares keep the parent on ties and let the left child win a child tie.
module max_pq_sel3
  import max_pq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] parent,
  input  logic [DATA_WIDTH-1:0] left,
  input  logic [DATA_WIDTH-1:0] right,
  input  logic                  left_vld,
  input  logic                  right_vld,
  output logic [1:0]            sel,
  output logic                  swap
);

  logic [DATA_WIDTH-1:0] best;

  always_comb begin
    best = parent;
    sel  = SEL_PARENT;
    if (left_vld && (left > best)) begin
      best = left;
      sel  = SEL_LEFT;
    end
    if (right_vld && (right > best)) begin
      best = right;
      sel  = SEL_RIGHT;
    end
    swap = (sel != SEL_PARENT);
  end

endmodule

// File: rtl/max_priority_queue.sv
// Binary max-heap queue, one tree level per cycle; PUSH/POP take 1..log2(depth)+1 cycles,
// ready_out/valid_out drop while sifting. Define MAX_PQ_COUNT_EN to expose count_out.
module max_priority_queue
  import max_pq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PQ_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic [1:0]            op,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] pq_out,
  output logic                  valid_out,
  input  logic                  ready_in
`ifdef MAX_PQ_COUNT_EN
  ,
  output logic [$clog2(PQ_DEPTH+1)-1:0] count_out
`endif
);

  localparam int CW = $clog2(PQ_DEPTH + 1);
  localparam int IW = $clog2(PQ_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(PQ_DEPTH);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [IW+1:0] TWO_C   = (IW + 2)'(2);

  logic [DATA_WIDTH-1:0] heap [PQ_DEPTH];
  logic [CW-1:0]         count;
  logic [IW-1:0]         idx;
  state_t                state;

  logic [IW-1:0] up_idx;
  logic [IW-1:0] last_idx;
  logic [IW+1:0] count_x;
  logic [IW+1:0] left_c;
  logic [IW+1:0] right_c;
  logic [IW-1:0] child;
  logic [1:0]    sel;
  logic          swap;

  assign ready_out = (state == S_IDLE) && (count < DEPTH_C);
  assign valid_out = (state == S_IDLE) && (count != '0);
  assign pq_out    = heap[0];

  // Index math is done one bit wider than the heap so children past the end
  // compare cleanly against count instead of wrapping.
  assign up_idx   = (idx - IDX_ONE) >> 1;
  assign last_idx = count[IW-1:0] - IDX_ONE;
  assign count_x  = {{(IW + 2 - CW){1'b0}}, count};
  assign left_c   = {1'b0, idx, 1'b1};
  assign right_c  = {1'b0, idx, 1'b0} + TWO_C;
  assign child    = (sel == SEL_LEFT) ? left_c[IW-1:0] : right_c[IW-1:0];

  max_pq_sel3 #(.DATA_WIDTH(DATA_WIDTH)) u_sel3 (
    .parent    (heap[idx]),
    .left      (heap[left_c[IW-1:0]]),
    .right     (heap[right_c[IW-1:0]]),
    .left_vld  (left_c < count_x),
    .right_vld (right_c < count_x),
    .sel       (sel),
    .swap      (swap)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      count <= '0;
      idx   <= '0;
      for (int i = 0; i < PQ_DEPTH; i++) heap[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((op == PQ_PUSH) && valid_in && ready_out) begin
            heap[count[IW-1:0]] <= data_in;
            idx   <= count[IW-1:0];
            count <= count + CNT_ONE;
            state <= S_SIFT_UP;
          end else if ((op == PQ_POP) && ready_in && valid_out) begin
            heap[0] <= heap[last_idx];
            count   <= count - CNT_ONE;
            idx     <= '0;
            state   <= S_SIFT_DOWN;
          end
        end
        S_SIFT_UP: begin
          if ((idx != '0) && (heap[idx] > heap[up_idx])) begin
            heap[idx]    <= heap[up_idx];
            heap[up_idx] <= heap[idx];
            idx          <= up_idx;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SIFT_DOWN: begin
          if (swap) begin
            heap[idx]   <= heap[child];
            heap[child] <= heap[idx];
            idx         <= child;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MAX_PQ_COUNT_EN
  assign count_out = count;
`endif

endmodule

// File: tb/tb_max_priority_queue.sv
// Table-driven bench for max_priority_queue with a software heap model and a
// scoreboard of expected popped keys, plus hand sequences for multi-cycle corners.
module tb_max_priority_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic [1:0] op = 2'b00;
  logic       ready_in = 1'b0;
  logic       ready_out;
  logic [7:0] pq_out;
  logic       valid_out;
`ifdef MAX_PQ_COUNT_EN
  logic [3:0] count_out;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  max_priority_queue #(.DATA_WIDTH(8), .PQ_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .op        (op),
    .ready_out (ready_out),
    .pq_out    (pq_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
`ifdef MAX_PQ_COUNT_EN
    ,
    .count_out (count_out)
`endif
  );

  typedef struct {
    bit       rst;
    bit [1:0] op;
    bit [7:0] data;
    bit       rdy_in;
    bit [7:0] exp_pq;
    bit       exp_vld;
    bit       exp_rdy;
    bit       chk_pq;
  } vec_t;

  vec_t vecs[$];
  int   model_q[$];
  int   exp_q[$];

  function automatic vec_t mk(bit rst, bit [1:0] o, bit [7:0] d, bit ri,
                              bit [7:0] pq, bit vld, bit rdy, bit chk);
    vec_t v;
    v.rst = rst; v.op = o; v.data = d; v.rdy_in = ri;
    v.exp_pq = pq; v.exp_vld = vld; v.exp_rdy = rdy; v.chk_pq = chk;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int model_max_idx();
    int mi = 0;
    for (int i = 1; i < model_q.size(); i++)
      if (model_q[i] > model_q[mi]) mi = i;
    return mi;
  endfunction

  task automatic wait_idle();
    for (int n = 0; n < 32; n++) begin
      if (ready_out || valid_out) return;
      @(negedge clk);
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic do_step(vec_t v);
    bit acc = 0;
    if (v.rst) begin
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_q.delete();
    end else begin
      @(negedge clk);
      op = v.op; data_in = v.data; valid_in = 1'b1; ready_in = v.rdy_in;
      if (v.op == 2'b01 && model_q.size() < 8) begin
        model_q.push_back(v.data);
        acc = 1;
      end else if (v.op == 2'b10 && v.rdy_in && model_q.size() > 0) begin
        int mi = model_max_idx();
        exp_q.push_back(model_q[mi]);
        model_q.delete(mi);
        acc = 1;
        chk("pop_consumed", pq_out, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      op = 2'b00; valid_in = 1'b0;
      if (acc) chk("busy_after_accept", {ready_out, valid_out}, 0);
      wait_idle();
    end
    chk("valid_out", valid_out, v.exp_vld);
    chk("ready_out", ready_out, v.exp_rdy);
    if (v.chk_pq) chk("pq_out", pq_out, v.exp_pq);
    if (model_q.size() > 0) chk("pq_out_model", pq_out, model_q[model_max_idx()]);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // rst, op, data, ready_in, exp_pq, exp_vld, exp_rdy, chk_pq
    vecs.push_back(mk(1, 2'b00, 0,   0, 0,   0, 1, 1));
    vecs.push_back(mk(0, 2'b01, 36,  0, 36,  1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 129, 0, 129, 1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 9,   0, 129, 1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 99,  0, 129, 1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 200, 0, 200, 1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 7,   0, 200, 1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 50,  0, 200, 1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 3,   0, 200, 1, 0, 1));
    vecs.push_back(mk(0, 2'b01, 255, 0, 200, 1, 0, 1));
    vecs.push_back(mk(0, 2'b11, 0,   0, 200, 1, 0, 1));
    vecs.push_back(mk(0, 2'b10, 0,   0, 200, 1, 0, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 129, 1, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 99,  1, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 50,  1, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 36,  1, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 9,   1, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 7,   1, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 3,   1, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 0,   0, 1, 0));
    vecs.push_back(mk(0, 2'b10, 0,   1, 0,   0, 1, 0));
    vecs.push_back(mk(1, 2'b00, 0,   0, 0,   0, 1, 1));
    vecs.push_back(mk(0, 2'b01, 13,  0, 13,  1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 141, 0, 141, 1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 101, 0, 141, 1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 18,  0, 141, 1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 1,   0, 141, 1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 13,  0, 141, 1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 118, 0, 141, 1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 61,  0, 141, 1, 0, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 118, 1, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 101, 1, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 61,  1, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 18,  1, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 13,  1, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 13,  1, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 1,   1, 1, 1));
    vecs.push_back(mk(0, 2'b10, 0,   1, 0,   0, 1, 0));
    vecs.push_back(mk(1, 2'b00, 0,   0, 0,   0, 1, 1));

    for (int i = 0; i < vecs.size(); i++) do_step(vecs[i]);

    // PUSH held for two cycles executes once.
    @(negedge clk);
    op = 2'b01; data_in = 8'd5; valid_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    op = 2'b00; valid_in = 1'b0;
    wait_idle();
    chk("hold_push_pq", pq_out, 5);
    chk("hold_push_vld", valid_out, 1);
`ifdef MAX_PQ_COUNT_EN
    chk("hold_push_count", count_out, 1);
`endif
    model_q.delete();
    model_q.push_back(5);
    do_step(mk(0, 2'b10, 0, 1, 0, 0, 1, 0));

    // Reset asserted while a pop is still sifting down.
    for (int k = 1; k <= 8; k++)
      do_step(mk(0, 2'b01, 8'(k * 10), 0, 8'(k * 10), 1, (k < 8), 1));
    @(negedge clk);
    op = 2'b10; ready_in = 1'b1;
    @(posedge clk);
    #1;
    op = 2'b00;
    chk("mid_sift_busy", {ready_out, valid_out}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_q.delete();
    chk("mid_sift_rst_vld", valid_out, 0);
    chk("mid_sift_rst_rdy", ready_out, 1);
    chk("mid_sift_rst_pq", pq_out, 0);
`ifdef MAX_PQ_COUNT_EN
    chk("mid_sift_rst_count", count_out, 0);
`endif
    do_step(mk(0, 2'b11, 0, 0, 0, 0, 1, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max_priority_queue.md
Name: max_priority_queue

Overview:
Max-priority queue (binary max-heap) of unsigned DATA_WIDTH-bit keys, up to PQ_DEPTH entries, stored in a flat register array. Non-pipelined: each PUSH/POP runs a multi-cycle sift FSM that moves one tree level per cycle. The largest stored value is always presented on pq_out. Sits between a producer (valid_in/ready_out) and a consumer (valid_out/ready_in).

Parameters:
DATA_WIDTH, 8, key width in bits (unsigned compare)
PQ_DEPTH, 8, maximum entries; any value >= 2

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
data_in  in  DATA_WIDTH  key to push
valid_in  in  1  data_in valid (PUSH qualifier)
op  in  2  00 NOP, 01 PUSH, 10 POP, 11 TOP
ready_out  out  1  queue can accept a PUSH
pq_out  out  DATA_WIDTH  current maximum (heap[0])
valid_out  out  1  pq_out holds a valid maximum
ready_in  in  1  consumer ready (POP qualifier)

Behaviour:
- State: heap[0..PQ_DEPTH-1], count (0..PQ_DEPTH), idx, FSM {IDLE, SIFT_UP, SIFT_DOWN}.
- Reset (reset==0 at posedge): count=0, FSM=IDLE, all heap entries 0. Outputs: ready_out=1, valid_out=0, pq_out=0. Reset mid-sift aborts the sift and empties the queue.
- ready_out = (FSM==IDLE) && (count<PQ_DEPTH), combinational.
- valid_out = (FSM==IDLE) && (count!=0), combinational. pq_out = heap[0], combinational, regardless of valid_out.
- PUSH accepted at posedge when op==01 && valid_in && ready_out: heap[count]<=data_in, idx<=count, count<=count+1, FSM->SIFT_UP. PUSH while not ready is ignored, with no state change.
- SIFT_UP (one cycle per level): if idx>0 && heap[idx] > heap[(idx-1)/2], swap and set idx=parent; otherwise FSM->IDLE. Ties do not swap.
- POP accepted when op==10 && ready_in && valid_out: heap[0]<=heap[count-1], count<=count-1, idx<=0, FSM->SIFT_DOWN. POP on empty or busy queue is ignored.
- SIFT_DOWN: among idx and children 2idx+1 and 2idx+2 that are < count, pick the largest (left child wins a child tie). If it is a child strictly greater than heap[idx], swap and set idx=child; otherwise FSM->IDLE.
- Every accepted PUSH/POP occupies at least one non-IDLE cycle, so ready_out/valid_out drop for >=1 cycle. An op held for two cycles therefore executes only once.
- Latency: PUSH 1..ceil(log2(PQ_DEPTH))+1 cycles; POP likewise. New max visible on pq_out when FSM returns to IDLE.
- TOP (11) and NOP (00): no state change. TOP is an observation cycle; pq_out/valid_out behave as at any idle cycle.
- op is ignored while FSM != IDLE.
- Full: count==PQ_DEPTH forces ready_out=0. Empty: valid_out=0.

Optional Feature:
Macro MAX_PQ_COUNT_EN. When defined, adds output port count_out of width $clog2(PQ_DEPTH+1) carrying the registered count; it resets to 0 and updates on the accepting edge of PUSH/POP. When undefined, the port and related logic are absent; all other behaviour is identical.

Decomposition:
- Package max_pq_pkg: op enum (PQ_NOP, PQ_PUSH, PQ_POP, PQ_TOP) and FSM state enum.
- One natural sub-module, max_pq_sel3: combinational largest-of-parent/left/right with child-valid inputs; returns the selected index and a swap flag. Used by SIFT_DOWN.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> ready_out=1, valid_out=0, pq_out=0.
- Push 36,129,9,99 (each accepted once, wait for ready_out) -> pq_out=129, valid_out=1 after the final sift.
- Fill to 8 entries -> ready_out=0; an extra PUSH of 255 is ignored and pq_out is unchanged.
- With 8 entries 13,141,101,18,1,13,118,61: POP repeatedly with ready_in=1 -> pq_out sequence 141,118,101,61,18,13,13,1, then valid_out=0.
- Hold op=PUSH for 2 cycles with data 5 on an empty queue -> count=1 (single push), pq_out=5.
- Reset asserted mid-SIFT_DOWN -> next cycle count=0, valid_out=0, ready_out=1. TOP with ready_in=0 -> state unchanged.
